imem_arbiter: RTL and testbench

Owns the single port of the instruction memory. It shares that port between the IF-stage fetch path and a program-loader/debug write port. After reset it runs a boot phase in which the loader fills instruction memory while fetch is held. It then runs a fetch-priority phase with a starvation guard for loader writes, and it generates the IF-stage stall.

---
 rtl/imem_arbiter.sv | 124 ++++++++++++
 tb/tb_imem_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/imem_arbiter.sv
// Instruction-memory port arbiter.
// Shares the single instruction-memory port between the IF-stage fetch path
// and the program-loader/debug write port. After reset it runs a boot phase
// in which fetch is held while the loader fills memory. It then runs a
// fetch-priority phase, with a starvation guard that forces a loader slot.
// It also drives the IF-stage stall.
module imem_arbiter #(
  parameter int ADDR_W     = 6,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              boot_en,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              stall_if,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_wdata,
  input  logic              ld_last,
  output logic              ld_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  output logic              busy,
  output logic [ADDR_W:0]   ld_cnt
);

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [3:0]      STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [ADDR_W:0] CNT_MAX    = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] CNT_ONE    = {{ADDR_W{1'b0}}, 1'b1};

  state_e          state_q, state_d;
  logic [3:0]      starve_q, starve_d;
  logic [ADDR_W:0] ld_cnt_q, ld_cnt_d;

  // Raw grants feed next-state logic; the outputs are additionally forced
  // off while reset is asserted, so reset never reaches a flop data input.
  logic if_gnt_raw, ld_gnt_raw, stall_raw, busy_raw;
  logic boot_skip, ld_force;

  // Grant arbitration and next-state logic for state, starve counter and load count
  always_comb begin
    if_gnt_raw = 1'b0;
    ld_gnt_raw = 1'b0;
    stall_raw  = 1'b1;
    busy_raw   = 1'b1;
    state_d    = state_q;
    starve_d   = starve_q;
    // Skipping boot is only possible before the first loader beat lands.
    boot_skip  = ~boot_en & (ld_cnt_q == '0);
    ld_force   = ld_req & (starve_q == STARVE_LIM);

    case (state_q)
      BOOT: begin
        starve_d = '0;
        if (boot_skip) begin
          // Transition cycle: no grant is issued while leaving boot.
          state_d = RUN;
        end else begin
          ld_gnt_raw = ld_req;
          if (ld_req && ld_last) begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        busy_raw = 1'b0;
        if (ld_force) begin
          ld_gnt_raw = 1'b1;
        end else if (if_req) begin
          if_gnt_raw = 1'b1;
        end else if (ld_req) begin
          ld_gnt_raw = 1'b1;
        end
        stall_raw = if_req & ~if_gnt_raw;
        // Count consecutive denied loader cycles; any grant or idle loader clears it.
        if (ld_req && !ld_gnt_raw) begin
          starve_d = (starve_q >= STARVE_LIM) ? STARVE_LIM : starve_q + 4'd1;
        end else begin
          starve_d = '0;
        end
      end
      default: begin
        state_d  = BOOT;
        starve_d = '0;
      end
    endcase

    ld_cnt_d = (ld_gnt_raw && (ld_cnt_q != CNT_MAX)) ? ld_cnt_q + CNT_ONE : ld_cnt_q;
  end

  // State, starvation counter and saturating load counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= BOOT;
      starve_q <= '0;
      ld_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      ld_cnt_q <= ld_cnt_d;
    end
  end

  // Output gating and memory port mux
  always_comb begin
    if_gnt    = if_gnt_raw & reset_n;
    ld_gnt    = ld_gnt_raw & reset_n;
    stall_if  = stall_raw | ~reset_n;
    busy      = busy_raw | ~reset_n;
    mem_we    = ld_gnt;
    mem_addr  = ld_gnt ? ld_addr : if_addr;
    mem_wdata = ld_wdata;
    ld_cnt    = ld_cnt_q;
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Scoreboard testbench for imem_arbiter. Two instances share the stimulus:
// the default ADDR_W=6 build and an ADDR_W=2 build whose load counter saturates.
module tb_imem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        boot_en;
  logic        if_req;
  logic [5:0]  if_addr;
  logic        ld_req;
  logic [5:0]  ld_addr;
  logic [31:0] ld_wdata;
  logic        ld_last;

  logic        if_gnt, stall_if, ld_gnt, mem_we, busy;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [6:0]  ld_cnt;

  logic        if_gnt_b, stall_if_b, ld_gnt_b, mem_we_b, busy_b;
  logic [1:0]  mem_addr_b;
  logic [31:0] mem_wdata_b;
  logic [2:0]  ld_cnt_b;

  logic [31:0] tb_mem [64];

  typedef struct {
    bit          ig;
    bit          lg;
    bit          st;
    bit          bz;
    logic [5:0]  addr;
    int          cnt;
    bit          rdchk;
    logic [31:0] rd;
  } exp_t;

  exp_t  exp_q[$];
  string nm_q[$];
  int    tests = 0;
  int    fails = 0;

  always #5 clk = ~clk;

  imem_arbiter #(.ADDR_W(6), .STARVE_MAX(3)) dut (
    .clk(clk), .reset_n(reset_n), .boot_en(boot_en),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .stall_if(stall_if),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_last(ld_last),
    .ld_gnt(ld_gnt), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .busy(busy), .ld_cnt(ld_cnt)
  );

  imem_arbiter #(.ADDR_W(2), .STARVE_MAX(3)) dut_b (
    .clk(clk), .reset_n(reset_n), .boot_en(boot_en),
    .if_req(if_req), .if_addr(if_addr[1:0]), .if_gnt(if_gnt_b), .stall_if(stall_if_b),
    .ld_req(ld_req), .ld_addr(ld_addr[1:0]), .ld_wdata(ld_wdata), .ld_last(ld_last),
    .ld_gnt(ld_gnt_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_we(mem_we_b),
    .busy(busy_b), .ld_cnt(ld_cnt_b)
  );

  // Instruction memory model: samples on the falling edge
  always @(negedge clk) begin
    if (mem_we) tb_mem[mem_addr] <= mem_wdata;
  end

  // Monitor: pops one expectation per cycle and compares both instances
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string nm;
      int    cnt_b;
      bit    ok;
      e  = exp_q.pop_front();
      nm = nm_q.pop_front();
      cnt_b = (e.cnt > 4) ? 4 : e.cnt;
      ok = (if_gnt == e.ig) && (ld_gnt == e.lg) && (stall_if == e.st) &&
           (busy == e.bz) && (mem_we == e.lg) && (mem_addr == e.addr) &&
           (mem_wdata == ld_wdata) && (ld_cnt == 7'(e.cnt)) && !(if_gnt && ld_gnt) &&
           (if_gnt_b == e.ig) && (ld_gnt_b == e.lg) && (stall_if_b == e.st) &&
           (busy_b == e.bz) && (mem_we_b == e.lg) && (mem_addr_b == e.addr[1:0]) &&
           (mem_wdata_b == ld_wdata) && (ld_cnt_b == 3'(cnt_b)) && !(if_gnt_b && ld_gnt_b);
      if (e.rdchk && (tb_mem[mem_addr] !== e.rd)) ok = 1'b0;
      tests++;
      if (!ok) begin
        fails++;
        $display("FAIL %s: got ig=%0b lg=%0b st=%0b bz=%0b we=%0b addr=%0d cnt=%0d | b: ig=%0b lg=%0b st=%0b bz=%0b addr=%0d cnt=%0d rd=%h ; want ig=%0b lg=%0b st=%0b bz=%0b addr=%0d cnt=%0d cnt_b=%0d rd=%h",
                 nm, if_gnt, ld_gnt, stall_if, busy, mem_we, mem_addr, ld_cnt,
                 if_gnt_b, ld_gnt_b, stall_if_b, busy_b, mem_addr_b, ld_cnt_b, tb_mem[mem_addr],
                 e.ig, e.lg, e.st, e.bz, e.addr, e.cnt, cnt_b, e.rd);
      end
    end
  end

  // Push the expected response for the current inputs, then advance one cycle
  task automatic chk(input string nm, input bit ig, input bit lg, input bit st,
                     input bit bz, input int cnt, input bit rdchk = 1'b0,
                     input logic [31:0] rd = 32'h0);
    exp_t e;
    e.ig = ig; e.lg = lg; e.st = st; e.bz = bz;
    e.addr = lg ? ld_addr : if_addr;
    e.cnt = cnt; e.rdchk = rdchk; e.rd = rd;
    exp_q.push_back(e);
    nm_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit ifr, input logic [5:0] ifa, input bit ldr,
                        input logic [5:0] lda, input logic [31:0] wd, input bit last);
    if_req = ifr; if_addr = ifa; ld_req = ldr; ld_addr = lda; ld_wdata = wd; ld_last = last;
  endtask

  initial begin
    reset_n = 1'b0;
    boot_en = 1'b1;
    set_in(1'b1, 6'd7, 1'b1, 6'd1, 32'hDEAD_BEEF, 1'b0);
    @(posedge clk);
    #1;
    // Reset: grants suppressed even with both requests active
    chk("reset_outputs", 0, 0, 1, 1, 0);
    reset_n = 1'b1;

    // Boot load of 4 beats with fetch requesting throughout
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 6'd3, 1'b1, 6'(i), 32'h0000_0013 + 32'(i), i == 3);
      chk("boot_beat", 0, 1, 1, 1, i);
    end
    // Now in RUN: fetch of address 2 sees data written during boot
    set_in(1'b1, 6'd2, 1'b0, 6'd0, 32'h0, 1'b0);
    chk("run_read2", 1, 0, 0, 0, 4, 1'b1, 32'h0000_0015);

    // Starvation guard: fetch and loader both held, loader forced every 4th cycle
    for (int i = 0; i < 8; i++) begin
      set_in(1'b1, 6'd5, 1'b1, 6'd10, 32'hA5A5_0000 + 32'(i), 1'b0);
      if ((i % 4) == 3) chk("starve_force", 0, 1, 1, 0, 4 + i / 4);
      else              chk("starve_fetch", 1, 0, 0, 0, 4 + i / 4);
    end

    // Loader alone: granted at once, starve counter left at 0
    set_in(1'b0, 6'd5, 1'b1, 6'd11, 32'h1111_2222, 1'b1);
    chk("ld_only", 0, 1, 0, 0, 6);
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 6'd6, 1'b1, 6'd12, 32'h3333_4444, 1'b0);
      chk("fetch_after_ld", 1, 0, 0, 0, 7);
    end
    set_in(1'b1, 6'd6, 1'b1, 6'd12, 32'h3333_4444, 1'b0);
    chk("force_after_ld", 0, 1, 1, 0, 7);
    set_in(1'b0, 6'd6, 1'b0, 6'd12, 32'h0, 1'b0);
    chk("idle_sat", 0, 0, 0, 0, 8);

    // Reset mid-boot after 2 beats
    reset_n = 1'b0;
    chk("reset_from_run", 0, 0, 1, 1, 0);
    reset_n = 1'b1;
    set_in(1'b1, 6'd4, 1'b1, 6'd0, 32'hCAFE_0000, 1'b0);
    chk("boot2_beat0", 0, 1, 1, 1, 0);
    boot_en = 1'b0;
    set_in(1'b1, 6'd4, 1'b1, 6'd1, 32'hCAFE_0001, 1'b0);
    chk("boot2_beat1_booten0", 0, 1, 1, 1, 1);
    boot_en = 1'b1;
    set_in(1'b1, 6'd4, 1'b1, 6'd2, 32'hCAFE_0002, 1'b0);
    reset_n = 1'b0;
    chk("reset_midburst", 0, 0, 1, 1, 0);
    reset_n = 1'b1;
    set_in(1'b1, 6'd4, 1'b0, 6'd2, 32'h0, 1'b1);
    chk("boot_last_noreq", 0, 0, 1, 1, 0);
    set_in(1'b1, 6'd4, 1'b1, 6'd0, 32'hBEEF_0000, 1'b1);
    chk("boot_single_beat", 0, 1, 1, 1, 0);
    set_in(1'b1, 6'd8, 1'b0, 6'd0, 32'h0, 1'b0);
    chk("run_after_single", 1, 0, 0, 0, 1);

    // Reset with boot skipped: one busy cycle, no grant even with loader requesting
    boot_en = 1'b0;
    reset_n = 1'b0;
    chk("reset_noboot", 0, 0, 1, 1, 0);
    reset_n = 1'b1;
    set_in(1'b1, 6'd9, 1'b1, 6'd13, 32'h5555_6666, 1'b0);
    chk("skip_cycle", 0, 0, 1, 1, 0);
    set_in(1'b1, 6'd9, 1'b0, 6'd13, 32'h0, 1'b0);
    chk("run_noboot_fetch", 1, 0, 0, 0, 0);
    set_in(1'b0, 6'd9, 1'b1, 6'd14, 32'h7777_8888, 1'b0);
    chk("run_noboot_ld", 0, 1, 0, 0, 0);
    set_in(1'b0, 6'd9, 1'b0, 6'd14, 32'h0, 1'b0);
    chk("run_noboot_idle", 0, 0, 0, 0, 1);

    // Drain the scoreboard with a bounded wait
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    if (exp_q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
